uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (PISO serializer + baud generator) between NUM_REQ byte producers.

---
 rtl/uart_tx_arb_pkg.sv | 10 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 89 ++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM encoding and parameter defaults for the UART transmit arbiter
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals around the arbiter (slave = arbiter side)
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] ack;
  logic tx_enable;
  logic [DATA_WIDTH-1:0] tx_data;
  logic tx_busy;
  logic grant_valid;
  logic [ID_WIDTH-1:0] grant_id;
  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, tx_enable, tx_data, grant_valid, grant_id
  );
  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, tx_enable, tx_data, grant_valid, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req strictly after ptr (wrapping)
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] c;
  // scan farthest to nearest so the nearest candidate after ptr is the last assignment
  always_comb begin
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = W'((int'(ptr) + k) % N);
      if (req[c]) idx = c;
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; UART_TX_PKT_LOCK_EN holds the grant for a whole packet
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH = 2
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  state_t state, next;
  logic [ID_WIDTH-1:0] rr_ptr, pick_idx, win;
  logic [DATA_WIDTH-1:0] data_sel;
  logic pick_any, fire, launch, done;
  rr_pick #(.N(NUM_REQ), .W(ID_WIDTH)) u_pick (
    .req(bus.req),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
`ifdef UART_TX_PKT_LOCK_EN
  logic locked, last_q;
  assign win = locked ? bus.grant_id : pick_idx;
  assign fire = !bus.tx_busy && (locked ? bus.req[bus.grant_id] : pick_any);
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign win = pick_idx;
  assign fire = !bus.tx_busy && pick_any;
`endif
  assign launch = state == IDLE && fire;
  assign done = state == WAIT_DONE && !bus.tx_busy;
  // select the winner's byte from the flattened request bus
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == ID_WIDTH'(i)) data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // next state: launch on a grant, advance on busy rise, return to idle on busy fall
  always_comb begin
    next = (state == IDLE)      ? (fire ? LAUNCH : IDLE) :
           (state == LAUNCH)    ? (bus.tx_busy ? WAIT_DONE : LAUNCH) :
           (state == WAIT_DONE) ? (bus.tx_busy ? WAIT_DONE : IDLE) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // outputs, captured byte, grant bookkeeping and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ack <= '0;
      bus.tx_enable <= 1'b0;
      bus.tx_data <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_id <= '0;
      rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
`ifdef UART_TX_PKT_LOCK_EN
      locked <= 1'b0;
      last_q <= 1'b0;
`endif
    end else begin
      bus.ack <= launch ? (NUM_REQ'(1) << win) : '0;
      bus.tx_enable <= state == LAUNCH && !bus.tx_busy;
      if (launch) begin
        bus.tx_data <= data_sel;
        bus.grant_id <= win;
        bus.grant_valid <= 1'b1;
`ifdef UART_TX_PKT_LOCK_EN
        last_q <= bus.req_last[win];
`else
        rr_ptr <= win;
`endif
      end
      if (done) begin
`ifdef UART_TX_PKT_LOCK_EN
        locked <= !last_q;
        bus.grant_valid <= !last_q;
        if (last_q) rr_ptr <= bus.grant_id;
`else
        bus.grant_valid <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter against a simple transmitter and arbitration model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) bus ();
  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  int tests = 0, fails = 0;
  logic busy_m = 1'b0, busy_force = 1'b0;
  int dly = 0, hold = 0;
  assign bus.tx_busy = busy_m | busy_force;
  // transmitter: busy rises 3 clk after enable is seen, stays high 20 clk
  always @(posedge clk) begin
    if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin busy_m <= 1'b1; hold <= 20; end
    end else if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) busy_m <= 1'b0;
    end else if (bus.tx_enable && !busy_m) dly <= 3;
  end
  int ack_cnt = 0;
  bit multi_ack = 1'b0;
  always @(negedge clk) begin
    if (|bus.ack) ack_cnt++;
    if ($countones(bus.ack) > 1) multi_ack = 1'b1;
  end
  int last_w = 3, lock_owner = -1;
  function automatic int pick(logic [3:0] m);
    if (lock_owner >= 0) return lock_owner;
    for (int k = 1; k <= 4; k++) if (m[2'((last_w + k) % 4)]) return (last_w + k) % 4;
    return -1;
  endfunction
  task automatic note(int w, bit last);
`ifdef UART_TX_PKT_LOCK_EN
    if (!last) lock_owner = w;
    else begin lock_owner = -1; last_w = w; end
`else
    last_w = w;
`endif
  endtask
  task automatic model_reset();
    last_w = 3;
    lock_owner = -1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_ack(output logic [3:0] a, output bit gap);
    bit prev_gv;
    a = '0;
    gap = 1'b0;
    prev_gv = bus.grant_valid;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (|bus.ack) begin
        a = bus.ack;
        gap = !prev_gv;
        return;
      end
      prev_gv = bus.grant_valid;
    end
    tests++;
    fails++;
    $error("FAIL ack_timeout observed=none expected=ack");
  endtask
  task automatic wait_busy(bit level);
    for (int i = 0; i < 300; i++) begin
      if (bus.tx_busy === level) return;
      tick();
    end
    tests++;
    fails++;
    $error("FAIL busy_timeout observed=%b expected=%b", bus.tx_busy, level);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!bus.grant_valid && !bus.tx_busy) return;
    end
    tests++;
    fails++;
    $error("FAIL done_timeout observed=%b expected=0", bus.grant_valid);
  endtask
  task automatic serve(logic [3:0] mask, logic [31:0] d);
    logic [3:0] a;
    bit g;
    int want;
    bus.req_data = d;
    bus.req_last = 4'hF;
    bus.req = mask;
    want = pick(mask);
    wait_ack(a, g);
    chk("rnd_ack", a, 1 << want);
    chk("rnd_data", bus.tx_data, 8'(d >> (8 * want)));
    chk("rnd_id", bus.grant_id, want);
    note(want, 1'b1);
    bus.req = '0;
    wait_done();
    chk("rnd_hold", bus.tx_data, 8'(d >> (8 * want)));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] a;
    bit g;
    int want, c, sent1;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = 4'hF;
    tick();
    tick();
    chk("rst_ack", bus.ack, 0);
    chk("rst_en", bus.tx_enable, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_gv", bus.grant_valid, 0);
    chk("rst_id", bus.grant_id, 0);
    model_reset();
    reset = 1'b0;
    // single request
    bus.req_data = 32'h0000_00A5;
    bus.req = 4'b0001;
    wait_ack(a, g);
    chk("t1_ack", a, 4'b0001);
    chk("t1_data", bus.tx_data, 8'hA5);
    chk("t1_id", bus.grant_id, 0);
    chk("t1_gv", bus.grant_valid, 1);
    chk("t1_en_at_ack", bus.tx_enable, 0);
    note(0, 1'b1);
    bus.req = '0;
    tick();
    chk("t1_en_rise", bus.tx_enable, 1);
    wait_busy(1'b1);
    chk("t1_en_until_busy", bus.tx_enable, 1);
    tick();
    chk("t1_en_drop", bus.tx_enable, 0);
    wait_done();
    chk("t1_data_hold", bus.tx_data, 8'hA5);
    // all requesting: strict rotation, one idle clk between frames
    bus.req_data = 32'hD3C2_B1A0;
    bus.req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      want = pick(4'hF);
      wait_ack(a, g);
      chk("t2_ack", a, 1 << want);
      chk("t2_data", bus.tx_data, 8'(32'hD3C2_B1A0 >> (8 * want)));
      chk("t2_gap", g, 1);
      chk("t2_busy_low", bus.tx_busy, 0);
      note(want, 1'b1);
    end
    bus.req = '0;
    wait_done();
    // busy left over from before reset blocks the first grant
    busy_force = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    bus.req_data = 32'h0055_0000;
    bus.req = 4'b0100;
    c = ack_cnt;
    repeat (8) tick();
    chk("t3_blocked", ack_cnt - c, 0);
    busy_force = 1'b0;
    wait_ack(a, g);
    chk("t3_ack", a, 4'b0100);
    chk("t3_data", bus.tx_data, 8'h55);
    note(2, 1'b1);
    bus.req = '0;
    wait_done();
    // reset two clocks into the wait for busy to fall
    bus.req_data = 32'h0000_6600;
    bus.req = 4'b0010;
    want = pick(4'b0010);
    wait_ack(a, g);
    chk("t4_ack", a, 1 << want);
    note(want, 1'b1);
    bus.req = '0;
    wait_busy(1'b1);
    tick();
    tick();
    reset = 1'b1;
    bus.req = 4'hF;
    tick();
    chk("t4_en", bus.tx_enable, 0);
    chk("t4_gv", bus.grant_valid, 0);
    chk("t4_ack0", bus.ack, 0);
    chk("t4_data0", bus.tx_data, 0);
    reset = 1'b0;
    model_reset();
    c = ack_cnt;
    wait_busy(1'b0);
    chk("t4_no_launch", ack_cnt - c, 0);
    want = pick(4'hF);
    wait_ack(a, g);
    chk("t4_ack_after", a, 1 << want);
    note(want, 1'b1);
    bus.req = '0;
    wait_done();
    // short pulse during a frame is never granted
    bus.req_data = 32'h0000_773C;
    bus.req = 4'b0001;
    wait_ack(a, g);
    chk("t5_ack", a, 4'b0001);
    note(0, 1'b1);
    bus.req = '0;
    wait_busy(1'b1);
    tick();
    tick();
    c = ack_cnt;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    bus.req_data[15:8] = 8'h99;
    wait_done();
    repeat (4) tick();
    chk("t5_no_ack", ack_cnt - c, 0);
    chk("t5_data", bus.tx_data, 8'h3C);
    // packet of three bytes from requester 1 competing with requester 0
    sent1 = 0;
    bus.req_data = 32'h0000_10E0;
    bus.req_last = 4'b0001;
    bus.req = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      want = pick(bus.req);
      wait_ack(a, g);
      chk("t6_ack", a, 1 << want);
      chk("t6_data", bus.tx_data, want == 1 ? 8'(8'h10 + sent1) : 8'hE0);
      note(want, bus.req_last[want]);
      if (want == 1) begin
        sent1++;
        if (sent1 == 3) bus.req[1] = 1'b0;
        else begin
          bus.req_data[15:8] = 8'(8'h10 + sent1);
          bus.req_last[1] = sent1 == 2;
        end
      end else bus.req[0] = 1'b0;
    end
    wait_done();
    chk("t6_released", bus.grant_valid, 0);
    // random request patterns
    for (int n = 0; n < 12; n++) serve(4'($urandom_range(1, 15)), $urandom);
    chk("one_hot_ack", multi_ack, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
